// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length and state enums,
// per-length Nk/Nr/Nw constants, storage depth and the xtime helper.
// Build option: AES_KS_256_EN enables AES-256 (storage depth 60); without it
// the depth is 52 and AES-256 is rejected as an illegal length.
package aes_pkg;

    localparam int unsigned AES256_WORDS = 60;

`ifdef AES_KS_256_EN
    localparam int unsigned KS_WORDS = AES256_WORDS;
    localparam int unsigned NR_MAX   = 14;
`else
    localparam int unsigned KS_WORDS = 52;
    localparam int unsigned NR_MAX   = 12;
`endif

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    localparam int unsigned NK_128 = 4;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NK_256 = 8;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;
    localparam int unsigned NW_128 = 4 * (NR_128 + 1);
    localparam int unsigned NW_192 = 4 * (NR_192 + 1);
    localparam int unsigned NW_256 = 4 * (NR_256 + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Ports: word_i (32) -> word_c (32), combinational.
module aes_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_c
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .in_byte (word_i[8*g +: 8]),
            .out_c   (word_c[8*g +: 8])
        );
    end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational.
// Ports: in_byte (8) -> out_c (8).
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_c
);

    localparam logic [7:0] INV_EXP = 8'hfe;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 by square-and-multiply; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            r = gf_mul(r, r);
            if (INV_EXP[k]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = gf_inv(in_byte);
        out_c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock,
// with a registered indexed round-key read port.
// Ports: clk, rst (sync, active-high); key[255:0] MSB-aligned, key_len[1:0],
// start -> busy, done (pulse), keys_valid, err (pulse);
// rk_idx[3:0] -> rk_data[127:0] (1-cycle latency).
// Build option: AES_KS_256_EN enables the AES-256 length and SubWord-at-i%8==4.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key,
    input  logic [1:0]   key_len,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         err,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data
);

    state_e        state_q, state_d;
    logic [5:0]    i_q, i_d;
    logic [2:0]    cnt_q, cnt_d;       // (Nk - i mod Nk) mod Nk; zero marks a RotWord step
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    nk_q, nk_d;
    logic [3:0]    nr_q, nr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          kv_q, kv_d;
    logic          err_q, err_d;
    logic [127:0]  rk_q, rk_d;
    logic [31:0]   mem_q [KS_WORDS];

    logic          legal, accept, expand_we;
    logic [3:0]    nk_new, nr_new;
    logic [5:0]    idx_prev, idx_back, last_idx;
    logic [31:0]   w_prev, w_back, sub_in, sub_out, t_word, w_new;

    // Length decode for the incoming request.
    always_comb begin
        legal  = 1'b1;
        nk_new = 4'(NK_128);
        nr_new = 4'(NR_128);
        case (key_len)
            KL_128: begin nk_new = 4'(NK_128); nr_new = 4'(NR_128); end
            KL_192: begin nk_new = 4'(NK_192); nr_new = 4'(NR_192); end
`ifdef AES_KS_256_EN
            KL_256: begin nk_new = 4'(NK_256); nr_new = 4'(NR_256); end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Word generation for w[i]; indices are clamped so IDLE never reads out of range.
    always_comb begin
        idx_prev = (i_q == 6'd0) ? 6'd0 : i_q - 6'd1;
        idx_back = (i_q < 6'(nk_q)) ? 6'd0 : i_q - 6'(nk_q);
        w_prev   = mem_q[idx_prev];
        w_back   = mem_q[idx_back];
        sub_in   = (cnt_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (cnt_q == 3'd0)
            t_word = sub_out ^ {rcon_q, 24'h0};
`ifdef AES_KS_256_EN
        else if (nk_q == 4'(NK_256) && cnt_q == 3'd4)
            t_word = sub_out;
`endif
        else
            t_word = w_prev;
        w_new    = w_back ^ t_word;
        last_idx = 6'({nr_q, 2'b00} + 6'd3);
    end

    aes_subword u_subword (
        .word_i (sub_in),
        .word_c (sub_out)
    );

    // Next-state, counters and read-port logic.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        cnt_d     = cnt_q;
        rcon_d    = rcon_q;
        nk_d      = nk_q;
        nr_d      = nr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        kv_d      = kv_q;
        err_d     = 1'b0;
        accept    = 1'b0;
        expand_we = 1'b0;
        rk_d      = 128'h0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        state_d = ST_EXPAND;
                        nk_d    = nk_new;
                        nr_d    = nr_new;
                        i_d     = 6'(nk_new);
                        cnt_d   = 3'd0;
                        rcon_d  = 8'h01;
                        kv_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                expand_we = 1'b1;
                i_d       = i_q + 6'd1;
                cnt_d     = (cnt_q == 3'd0) ? 3'(nk_q - 4'd1) : cnt_q - 3'd1;
                if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
                if (i_q == last_idx) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rk_idx <= nr_q && 32'(rk_idx) <= NR_MAX)
            rk_d = {mem_q[{rk_idx, 2'b00}], mem_q[{rk_idx, 2'b01}],
                    mem_q[{rk_idx, 2'b10}], mem_q[{rk_idx, 2'b11}]};
    end

    // Control and read registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= 6'd0;
            cnt_q   <= 3'd0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
            rk_q    <= 128'h0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            rk_q    <= rk_d;
        end
    end

    // Word storage and latched length; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nk_q <= nk_d;
            nr_q <= nr_d;
            if (accept) begin
                for (int k = 0; k < 8; k++)
                    if (k < 32'(nk_new)) mem_q[k] <= key[255 - 32*k -: 32];
            end else if (expand_we) begin
                mem_q[i_q] <= w_new;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign err        = err_q;
    assign rk_data    = rk_q;

endmodule
